// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for a single-port memory with fixed read latency.
// The fetch (if_*) and load/store (d_*) requesters hold level requests until they see a
// one-cycle ready pulse. One access runs at a time: IDLE -> ACCESS -> WAIT x MEM_LATENCY -> RESP.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request and address
//   if_ready/if_rdata             fetch completion pulse and registered read data
//   d_req/d_we/d_addr/d_wdata/d_be data request, direction, address, write data, byte enables
//   d_ready/d_rdata               data completion pulse and registered read data
//   mem_en/mem_we                 memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata/mem_be     registered access fields
//   mem_rdata                     memory read data, valid MEM_LATENCY cycles after mem_en
//   arb_busy                      high whenever the sequencer is not idle
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests;
// otherwise data always beats fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    arb_busy
);
    localparam int unsigned BeWidth  = DATA_WIDTH / 8;
    localparam int unsigned CntWidth = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    owner_data_q, owner_data_d;  // 1: data port owns the grant
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BeWidth-1:0]      be_q, be_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    grant_data;

`ifdef MEM_ARB_RR_EN
    // Remembers who won the previous grant; reset value (fetch) hands the first tie to data.
    logic last_data_q, last_data_d;

    assign grant_data  = d_req && (!if_req || !last_data_q);
    assign last_data_d = (state_q == StIdle && (if_req || d_req)) ? grant_data : last_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign grant_data = d_req;
`endif

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    owner_data_d = grant_data;
                    if (grant_data) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        be_d    = '0;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    // Last WAIT cycle: mem_rdata is valid now.
                    if (!we_q) begin
                        if (owner_data_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            StResp: begin
                // Requests are still held for the access just completed; do not re-sample here.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_data_q <= 1'b0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == StAccess);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_ready  = (state_q == StResp) && !owner_data_q;
    assign d_ready   = (state_q == StResp) && owner_data_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-2 instance driven by directed and randomized request
// sequences against a schedule/scoreboard model, plus a latency-1 instance for one read.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic        clk, rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        if_ready, d_ready, mem_en, mem_we, arb_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if_req1, if_ready1, d_ready1, mem_en1, mem_we1, arb_busy1;
    logic [31:0] if_addr1, if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_be1;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_be(mem_be1), .mem_rdata(mem_rdata1), .arb_busy(arb_busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input logic [7:0] i);
        if (i == 8'h40) return 32'h00500093;
        return {i, ~i, i ^ 8'h5A, 8'hC3};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] w = old;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        return w;
    endfunction

    // Memory environment: word array indexed by addr[9:2], reads valid LAT cycles after mem_en.
    logic [31:0] env_mem [256];
    bit          env_v   [256];
    logic [31:0] pipe_d  [LAT];
    logic        pipe_v  [LAT];
    logic [31:0] rd1_q;
    logic        vld1_q;

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_v[a[9:2]] ? env_mem[a[9:2]] : init_word(a[9:2]);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            env_mem[mem_addr[9:2]] <= merge(env_read(mem_addr), mem_wdata, mem_be);
            env_v[mem_addr[9:2]]   <= 1'b1;
        end
        pipe_d[0] <= env_read(mem_addr);
        pipe_v[0] <= mem_en && !mem_we;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
        rd1_q  <= env_read(mem_addr1);
        vld1_q <= mem_en1 && !mem_we1;
    end

    // Junk outside the valid slot exposes a capture on the wrong cycle.
    assign mem_rdata  = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hA5A5_5A5A;
    assign mem_rdata1 = vld1_q ? rd1_q : 32'hA5A5_5A5A;

    // Reference model state.
    logic [31:0] ref_mem [256];
    bit          ref_v   [256];
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_d_rdata  = 32'h0;
    logic        m_last_d   = 1'b0;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_v[a[9:2]] ? ref_mem[a[9:2]] : init_word(a[9:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk1("ready_exclusive", if_ready & d_ready, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk1({tag, "_if_ready"}, if_ready, 1'b0);
        chk1({tag, "_d_ready"}, d_ready, 1'b0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_arb_busy"}, arb_busy, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1000 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // Fetch side issues nf_in back-to-back accesses and data side nd_in, each holding its
    // request until ready. Every grant takes LAT+3 cycles; the winner at each IDLE decision
    // follows the arbitration rule. Entered and left at a negedge with the DUT idle.
    task automatic run_seq(input int nf_in, input int nd_in, input logic [31:0] fa0,
                           input logic [31:0] da0, input logic dwe0, input logic [31:0] dwd0,
                           input logic [3:0] dbe0);
        int   nf = nf_in;
        int   nd = nd_in;
        logic win;
        if_addr = fa0;
        d_addr  = da0;
        d_we    = dwe0;
        d_wdata = dwd0;
        d_be    = dbe0;
        if_req  = (nf > 0);
        d_req   = (nd > 0);
        while (nf > 0 || nd > 0) begin
`ifdef MEM_ARB_RR_EN
            win = (nd > 0) && (nf == 0 || !m_last_d);
`else
            win = (nd > 0);
`endif
            m_last_d = win;
            for (int c = 1; c <= LAT + 2; c++) begin
                step();
                if (c == LAT + 2) begin
                    if (win && !d_we) m_d_rdata = ref_read(d_addr);
                    if (!win) m_if_rdata = ref_read(if_addr);
                end
                chk1("mem_en", mem_en, c == 1);
                chk1("if_ready", if_ready, (c == LAT + 2) && !win);
                chk1("d_ready", d_ready, (c == LAT + 2) && win);
                chk1("arb_busy_active", arb_busy, 1'b1);
                chk("if_rdata", if_rdata, m_if_rdata);
                chk("d_rdata", d_rdata, m_d_rdata);
                if (c == 1) begin
                    chk1("mem_we", mem_we, win ? d_we : 1'b0);
                    chk("mem_addr", mem_addr, win ? d_addr : if_addr);
                    chk("mem_be", 32'(mem_be), win ? 32'(d_be) : 32'h0);
                    if (win && d_we) chk("mem_wdata", mem_wdata, d_wdata);
                end
            end
            if (win) begin
                if (d_we) begin
                    ref_mem[d_addr[9:2]] = merge(ref_read(d_addr), d_wdata, d_be);
                    ref_v[d_addr[9:2]]   = 1'b1;
                end
                nd--;
                if (nd > 0) begin
                    d_addr  = rand_addr();
                    d_we    = 1'($urandom_range(0, 1));
                    d_wdata = $urandom;
                    d_be    = 4'($urandom_range(1, 15));
                end else begin
                    d_req = 1'b0;
                end
            end else begin
                nf--;
                if (nf > 0) if_addr = rand_addr();
                else if_req = 1'b0;
            end
            step();
            chk1("idle_busy", arb_busy, 1'b0);
            chk1("idle_mem_en", mem_en, 1'b0);
            chk1("idle_if_ready", if_ready, 1'b0);
            chk1("idle_d_ready", d_ready, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        if_req1 = 1'b0; if_addr1 = 32'h0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        chk1("reset_busy1", arb_busy1, 1'b0);
        chk("reset_if_rdata1", if_rdata1, 32'h0);
        rst = 1'b0;

        // Latency-1 instance: mem_en at 1, capture at 2, ready at 3.
        if_addr1 = 32'h100;
        if_req1  = 1'b1;
        step();
        chk1("l1_mem_en_c1", mem_en1, 1'b1);
        chk("l1_mem_addr_c1", mem_addr1, 32'h100);
        step();
        chk1("l1_mem_en_c2", mem_en1, 1'b0);
        chk1("l1_ready_c2", if_ready1, 1'b0);
        chk("l1_rdata_c2", if_rdata1, 32'h0);
        step();
        chk1("l1_ready_c3", if_ready1, 1'b1);
        chk("l1_rdata_c3", if_rdata1, 32'h00500093);
        if_req1 = 1'b0;
        step();
        chk1("l1_ready_c4", if_ready1, 1'b0);
        chk1("l1_busy_c4", arb_busy1, 1'b0);
        chk1("l1_d_ready", d_ready1, 1'b0);

        // Single fetch of 0x100.
        run_seq(1, 0, 32'h100, 32'h0, 1'b0, 32'h0, 4'h0);
        chk("fetch_0x100", if_rdata, 32'h00500093);

        // Write to 0x2000: d_rdata must stay at its reset value.
        run_seq(0, 1, 32'h0, 32'h2000, 1'b1, 32'hDEADBEEF, 4'hF);
        chk("write_d_rdata_held", d_rdata, 32'h0);

        // Simultaneous single requests, then both held across several grants.
        run_seq(1, 1, 32'h104, 32'h108, 1'b0, 32'h0, 4'h0);
        run_seq(2, 4, 32'h10C, 32'h2000, 1'b0, 32'h0, 4'h0);

        // Reset at cycle 2 of a fetch read.
        if_addr = 32'h100;
        if_req  = 1'b1;
        step();
        chk1("rst_mid_mem_en_c1", mem_en, 1'b1);
        step();
        rst    = 1'b1;
        if_req = 1'b0;
        step();
        rst = 1'b0;
        chk_outputs_zero("rst_mid_c3");
        m_if_rdata = 32'h0;
        m_d_rdata  = 32'h0;
        m_last_d   = 1'b0;
        step();
        chk1("rst_mid_no_if_ready_c4", if_ready, 1'b0);
        chk1("rst_mid_no_d_ready_c4", d_ready, 1'b0);
        chk1("rst_mid_idle_c4", arb_busy, 1'b0);
        run_seq(1, 0, 32'h100, 32'h0, 1'b0, 32'h0, 4'h0);

        // Randomized mixes of fetch and data traffic.
        for (int r = 0; r < 25; r++) begin
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rand_addr(),
                    rand_addr(), 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(1, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
